even_parity_checker: RTL
========================

EVEN_PARITY_CHECKER -- requirements
Module: even_parity_checker

Interface
REQ-001: Parameter CNT_W, default 8, width of the error counter.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: in_valid  input  1  upstream word present on in_word.
REQ-005: in_ready  output  1  block can accept a word this cycle.
REQ-006: in_word  input  16  framed word: [7:0] data, [14:8] reserved (zero), [15] even-parity bit.
REQ-007: out_valid  output  1  checked entry present at FIFO head.
REQ-008: out_ready  input  1  downstream accepts head entry.
REQ-009: out_data  output  8  data field of head entry.
REQ-010: out_perr  output  1  parity error flag of head entry.
REQ-011: out_ferr  output  1  format error flag of head entry (reserved bits non-zero).
REQ-012: clr_count  input  1  synchronous clear of err_count and err_sticky.
REQ-013: err_count  output  CNT_W  saturating count of accepted erroneous words.
REQ-014: err_sticky  output  1  set on first accepted erroneous word, held until clr_count or reset.

Function
REQ-015: A word SHALL be accepted only in a cycle with in_valid=1 and in_ready=1.
REQ-016: perr SHALL equal in_word[15] XOR (XOR-reduction of in_word[7:0]); reserved bits SHALL NOT affect perr.
REQ-017: ferr SHALL be 1 when in_word[14:8] != 0.
REQ-018: Each accepted word SHALL be stored as {data, perr, ferr} in a 2-entry FIFO; entries SHALL emerge in acceptance order.
REQ-019: FIFO occupancy SHALL be a state machine EMPTY, ONE, FULL: push-only advances one state, pop-only retreats one state, push+pop in ONE stays in ONE.
REQ-020: in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, independent of out_ready (no combinational path out_ready->in_ready).
REQ-021: out_valid SHALL be 1 in ONE and FULL; out_data/out_perr/out_ferr SHALL reflect the oldest entry and be stable while out_valid=1 and out_ready=0.
REQ-022: Latency: a word accepted in cycle N into EMPTY SHALL appear with out_valid=1 in cycle N+1.
REQ-023: A pop SHALL occur when out_valid=1 and out_ready=1; out_ready while EMPTY SHALL have no effect.
REQ-024: In FULL, a pop SHALL NOT be combined with a push that cycle (in_ready=0); next cycle state is ONE.
REQ-025: err_count SHALL increment by 1 per accepted word with perr|ferr, saturating at 2^CNT_W-1.
REQ-026: clr_count SHALL take priority over a same-cycle increment: err_count=0, err_sticky=0 next cycle.
REQ-027: When out_valid=0, out_data, out_perr, out_ferr SHALL be 0.

Reset
REQ-028: rst SHALL asynchronously force state EMPTY, in_ready=1, out_valid=0, out_data=0, out_perr=0, out_ferr=0, err_count=0, err_sticky=0.
REQ-029: Reset mid-transfer SHALL discard all FIFO contents; no entry SHALL appear after reset release without a new acceptance.
REQ-030: First acceptance SHALL be possible in the first rising edge after rst deasserts.

Structure
REQ-031: Shared package even_parity_pkg SHALL hold DATA_W=8, WORD_W=16, PAR_BIT=15, RSV_LO=8, RSV_HI=14 and the FIFO state enum {EMPTY, ONE, FULL}.
REQ-032: The XOR reduction SHALL be a sub-module parity_xor8 (8-bit balanced XOR tree, combinational), shared with the generator side.

Verification
REQ-033: After reset, in_word=0x0055 with out_ready=1 -> next cycle out_valid=1, out_data=0x55, perr=0, ferr=0, err_count=0.
REQ-034: in_word=0x8001 then 0x0001 -> entries {0x01,0,0} then {0x01,1,0}; err_count=1, err_sticky=1.
REQ-035: in_word=0x0300 -> {0x00, perr=0, ferr=1}; in_word=0x0101 -> {0x01, perr=1, ferr=1}; err_count +2.
REQ-036: out_ready=0, push 0x8080, 0x00AA, 0x0011 back-to-back -> first two accepted, in_ready=0 on third; raise out_ready -> 0x80, 0xAA in order, then 0x11 accepted.
REQ-037: CNT_W=2, push 5 words with bad parity -> err_count saturates at 3; clr_count asserted with a bad word same cycle -> err_count=0.
REQ-038: Assert rst while FULL -> out_valid=0, in_ready=1 immediately; no stale entry after release.

Source files
------------

// File: rtl/even_parity_pkg.sv
// Shared constants, FIFO state encoding and entry layout for the even-parity checker.
// The generator side of the link imports the same definitions.
package even_parity_pkg;

    localparam int DATA_W  = 8;
    localparam int WORD_W  = 16;
    localparam int PAR_BIT = 15;
    localparam int RSV_LO  = 8;
    localparam int RSV_HI  = 14;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              perr;
        logic              ferr;
    } entry_t;

endpackage

// File: rtl/parity_xor8.sv
// Combinational 8-bit XOR reduction as a balanced three-level tree.
// The generator side of the link instantiates this same module.
module parity_xor8 (
    input  logic [7:0] data_i,
    output logic       parity_o
);

    logic [3:0] lvl1;
    logic [1:0] lvl2;

    assign lvl1[0] = data_i[0] ^ data_i[1];
    assign lvl1[1] = data_i[2] ^ data_i[3];
    assign lvl1[2] = data_i[4] ^ data_i[5];
    assign lvl1[3] = data_i[6] ^ data_i[7];

    assign lvl2[0] = lvl1[0] ^ lvl1[1];
    assign lvl2[1] = lvl1[2] ^ lvl1[3];

    assign parity_o = lvl2[0] ^ lvl2[1];

endmodule

// File: rtl/even_parity_checker.sv
// Checks even parity and reserved-field format of framed 16-bit words, queues the
// results in a 2-entry FIFO and keeps a saturating error counter with a sticky flag.
module even_parity_checker
    import even_parity_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_ferr,
    input  logic              clr_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky,
    output logic [1:0]        state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready and out_valid are registered from the occupancy state only, so neither
    // depends combinationally on in_valid or out_ready.

    fifo_state_e      state_q;
    entry_t           head_q;
    entry_t           tail_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sticky_q, sticky_d;

    logic   data_parity;
    entry_t new_entry;
    logic   push;
    logic   pop;

    parity_xor8 u_parity_xor8 (
        .data_i   (in_word[DATA_W-1:0]),
        .parity_o (data_parity)
    );

    always_comb begin
        new_entry.data = in_word[DATA_W-1:0];
        new_entry.perr = in_word[PAR_BIT] ^ data_parity;
        new_entry.ferr = |in_word[RSV_HI:RSV_LO];
    end

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // The head register is zeroed whenever the FIFO drains, so the output fields
    // read as zero with out_valid low without any output gating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_q      <= new_entry;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_q <= new_entry;
                    end else if (push) begin
                        tail_q     <= new_entry;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        head_q      <= '0;
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_q     <= tail_q;
                        tail_q     <= '0;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    head_q      <= '0;
                    tail_q      <= '0;
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle increment; the count holds at all-ones.
    always_comb begin
        count_d  = count_q;
        sticky_d = sticky_q;
        if (clr_count) begin
            count_d  = '0;
            sticky_d = 1'b0;
        end else if (push && (new_entry.perr || new_entry.ferr)) begin
            sticky_d = 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = head_q.data;
    assign out_perr   = head_q.perr;
    assign out_ferr   = head_q.ferr;
    assign err_count  = count_q;
    assign err_sticky = sticky_q;
    assign state_dbg  = state_q;

endmodule
